// File: rtl/fc_layer_param.sv
// Parametrised fully-connected layer: y[i] = act(b[i] + sum_j W[i*N+j]*x[j]).
// Ping-pong input banks feed a single MAC; weights and biases come from external synchronous ROMs.
module fc_layer_param #(
  parameter int M    = 8,
  parameter int N    = 8,
  parameter int T    = 20,
  parameter int RELU = 1,
  parameter int SAT  = 1,
  parameter int WA   = $clog2(M*N),
  parameter int BA   = (M > 1) ? $clog2(M) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic signed [T-1:0] data_in,
  output logic                m_valid,
  input  logic                m_ready,
  output logic signed [T-1:0] data_out,
  output logic [WA-1:0]       w_addr,
  input  logic signed [T-1:0] w_data,
  output logic [BA-1:0]       b_addr,
  input  logic signed [T-1:0] b_data
);
  localparam int JW   = $clog2(N);
  localparam int ACCW = 2*T + $clog2(N) + 1;

  typedef enum logic [1:0] {C_IDLE, C_MAC, C_DRAIN, C_OUT} cstate_t;

  // loader state
  logic [1:0]    full_q, full_d;
  logic          load_bank_q, load_bank_d;
  logic [JW-1:0] beat_q, beat_d;
  logic          s_ready_q, s_ready_d;
  logic          rst_done_q;
  logic          accept, load_done, release_bank;

  // compute state
  cstate_t       state_q, state_d;
  logic          cbank_q, cbank_d;
  logic [BA-1:0] row_q, row_d;
  logic [JW-1:0] col_q, col_d;
  logic [WA-1:0] waddr_q, waddr_d;
  logic [1:0]    avail;
  logic          out_load;

  // datapath
  logic signed [T-1:0]    buf_mem [2][N];
  logic signed [T-1:0]    x_rd_q, bias_q;
  logic signed [2*T-1:0]  prod_q;
  logic signed [ACCW-1:0] acc_q;
  logic                   s1_v_q, s1_first_q, s2_v_q, s2_first_q;
  logic signed [T-1:0]    res;
  logic                   out_valid_q;
  logic signed [T-1:0]    out_data_q;

  assign accept    = s_valid && s_ready_q;
  assign load_done = accept && (beat_q == JW'(N-1));

  always_comb begin
    full_d      = full_q;
    load_bank_d = load_bank_q;
    beat_d      = beat_q;
    if (release_bank) full_d[cbank_q] = 1'b0;
    if (accept) begin
      if (load_done) begin
        beat_d              = '0;
        full_d[load_bank_q] = 1'b1;
        load_bank_d         = ~load_bank_q;
      end else begin
        beat_d = beat_q + 1'b1;
      end
    end
    s_ready_d = rst_done_q && !full_d[load_bank_d];
  end

  // A bank counts as available in the very cycle its last beat is accepted,
  // which saves the idle cycle on the first-result latency.
  for (genvar gi = 0; gi < 2; gi++) begin : g_avail
    assign avail[gi] = full_q[gi] || (load_done && (load_bank_q == 1'(gi)));
  end

  always_comb begin
    state_d      = state_q;
    cbank_d      = cbank_q;
    row_d        = row_q;
    col_d        = col_q;
    waddr_d      = waddr_q;
    release_bank = 1'b0;
    out_load     = 1'b0;
    case (state_q)
      C_IDLE: begin
        if (avail[cbank_q]) begin
          state_d = C_MAC;
          row_d   = '0;
          col_d   = '0;
          waddr_d = '0;
        end
      end
      C_MAC: begin
        if (col_q == JW'(N-1)) begin
          col_d   = '0;
          state_d = C_DRAIN;
        end else begin
          col_d   = col_q + 1'b1;
          waddr_d = waddr_q + 1'b1;
        end
      end
      C_DRAIN: begin
        if (col_q != '0) begin
          col_d   = '0;
          state_d = C_OUT;
        end else begin
          col_d = JW'(1);
        end
      end
      C_OUT: begin
        if (!out_valid_q || m_ready) begin
          out_load = 1'b1;
          if (row_q != BA'(M-1)) begin
            row_d   = row_q + 1'b1;
            waddr_d = waddr_q + 1'b1;
            state_d = C_MAC;
          end else begin
            release_bank = 1'b1;
            cbank_d      = ~cbank_q;
            row_d        = '0;
            waddr_d      = '0;
            state_d      = avail[~cbank_q] ? C_MAC : C_IDLE;
          end
        end
      end
      default: state_d = C_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      full_q      <= '0;
      load_bank_q <= 1'b0;
      beat_q      <= '0;
      s_ready_q   <= 1'b0;
      rst_done_q  <= 1'b0;
      state_q     <= C_IDLE;
      cbank_q     <= 1'b0;
      row_q       <= '0;
      col_q       <= '0;
      waddr_q     <= '0;
    end else begin
      full_q      <= full_d;
      load_bank_q <= load_bank_d;
      beat_q      <= beat_d;
      s_ready_q   <= s_ready_d;
      rst_done_q  <= 1'b1;
      state_q     <= state_d;
      cbank_q     <= cbank_d;
      row_q       <= row_d;
      col_q       <= col_d;
      waddr_q     <= waddr_d;
    end
  end

  // input banks: plain RAM with registered read
  always_ff @(posedge clk) begin
    if (accept) buf_mem[load_bank_q][beat_q] <= data_in;
    x_rd_q <= buf_mem[cbank_q][col_q];
  end

  // stage1: ROM data + x valid; stage2: registered product valid
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_v_q     <= 1'b0;
      s1_first_q <= 1'b0;
      s2_v_q     <= 1'b0;
      s2_first_q <= 1'b0;
      prod_q     <= '0;
      bias_q     <= '0;
      acc_q      <= '0;
    end else begin
      s1_v_q     <= (state_q == C_MAC);
      s1_first_q <= (state_q == C_MAC) && (col_q == '0);
      s2_v_q     <= s1_v_q;
      s2_first_q <= s1_first_q;
      if (s1_v_q) prod_q <= w_data * x_rd_q;
      if (s1_first_q) bias_q <= b_data;
      if (s2_v_q) begin
        if (s2_first_q)
          acc_q <= {{(ACCW-T){bias_q[T-1]}}, bias_q} + {{(ACCW-2*T){prod_q[2*T-1]}}, prod_q};
        else
          acc_q <= acc_q + {{(ACCW-2*T){prod_q[2*T-1]}}, prod_q};
      end
    end
  end

  // in range iff bits [ACCW-1:T-1] are all equal
  always_comb begin
    res = acc_q[T-1:0];
    if (SAT != 0) begin
      if (!acc_q[ACCW-1] && (acc_q[ACCW-2:T-1] != '0))
        res = {1'b0, {(T-1){1'b1}}};
      else if (acc_q[ACCW-1] && (acc_q[ACCW-2:T-1] != '1))
        res = {1'b1, {(T-1){1'b0}}};
    end
    if ((RELU != 0) && res[T-1]) res = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (out_load) begin
      out_valid_q <= 1'b1;
      out_data_q  <= res;
    end else if (m_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign s_ready  = s_ready_q;
  assign m_valid  = out_valid_q;
  assign data_out = out_data_q;
  assign w_addr   = waddr_q;
  assign b_addr   = row_q;

endmodule

// File: tb/tb_fc_layer_param.sv
// Directed bench for fc_layer_param: two instances (RELU/SAT on, and both off) share stimulus;
// each has its own synchronous weight/bias ROM model and expected-output queue.
module tb_fc_layer_param;
  localparam int M = 8;
  localparam int N = 8;
  localparam int T = 20;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic s_valid = 1'b0;
  logic bp_en = 1'b0;
  logic bp_rnd = 1'b1;
  logic m_ready;
  logic signed [T-1:0] data_in = '0;
  logic s_ready_a, m_valid_a, s_ready_b, m_valid_b;
  logic signed [T-1:0] dout_a, dout_b, wd_a, wd_b, bd_a, bd_b;
  logic [5:0] wa_a, wa_b;
  logic [2:0] ba_a, ba_b;

  logic signed [T-1:0] w_mem [M*N];
  logic signed [T-1:0] b_mem [M];

  int n_chk = 0;
  int n_err = 0;
  int n_pop_a = 0;
  int exp_a[$];
  int exp_b[$];
  logic hold_a = 1'b0;
  logic hold_b = 1'b0;
  logic signed [T-1:0] prev_a = '0;
  logic signed [T-1:0] prev_b = '0;
  int xv1 [N];
  int xv2 [N];
  int xv3 [N];
  int base;
  int k;

  assign m_ready = bp_en ? bp_rnd : 1'b1;

  always #5 clk = ~clk;

  fc_layer_param #(.M(M), .N(N), .T(T), .RELU(1), .SAT(1)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready_a), .data_in(data_in),
    .m_valid(m_valid_a), .m_ready(m_ready), .data_out(dout_a),
    .w_addr(wa_a), .w_data(wd_a), .b_addr(ba_a), .b_data(bd_a)
  );

  fc_layer_param #(.M(M), .N(N), .T(T), .RELU(0), .SAT(0)) dut_wrap (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready_b), .data_in(data_in),
    .m_valid(m_valid_b), .m_ready(m_ready), .data_out(dout_b),
    .w_addr(wa_b), .w_data(wd_b), .b_addr(ba_b), .b_data(bd_b)
  );

  always @(posedge clk) begin
    wd_a <= w_mem[wa_a];
    bd_a <= b_mem[ba_a];
    wd_b <= w_mem[wa_b];
    bd_b <= b_mem[ba_b];
  end

  always @(posedge clk) begin
    #1;
    bp_rnd = 1'($urandom_range(0, 1));
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // output monitor: order, value and hold-stability of both instances
  always @(negedge clk) begin : mon
    int e;
    if (!reset) begin
      if (hold_a) begin
        chk("hold_valid_a", m_valid_a, 1);
        chk("hold_data_a", dout_a, prev_a);
      end
      if (hold_b) begin
        chk("hold_valid_b", m_valid_b, 1);
        chk("hold_data_b", dout_b, prev_b);
      end
      if (m_valid_a && m_ready) begin
        e = (exp_a.size() > 0) ? exp_a.pop_front() : 2147483647;
        chk("y_relu_sat", dout_a, e);
        n_pop_a <= n_pop_a + 1;
        $display("%0t beat y_a=%0d exp=%0d y_b=%0d", $time, dout_a, e, dout_b);
      end
      if (m_valid_b && m_ready) begin
        e = (exp_b.size() > 0) ? exp_b.pop_front() : 2147483647;
        chk("y_wrap", dout_b, e);
      end
      hold_a <= m_valid_a && !m_ready;
      hold_b <= m_valid_b && !m_ready;
      prev_a <= dout_a;
      prev_b <= dout_b;
    end else begin
      hold_a <= 1'b0;
      hold_b <= 1'b0;
    end
  end

  function automatic int model(input int row, input int xv [N], input bit relu, input bit sat);
    longint acc;
    logic signed [T-1:0] lo;
    acc = longint'(b_mem[row]);
    for (int j = 0; j < N; j++) acc += longint'(w_mem[row*N+j]) * longint'(xv[j]);
    if (sat) begin
      if (acc > 524287) acc = 524287;
      if (acc < -524288) acc = -524288;
    end else begin
      lo = acc[T-1:0];
      acc = longint'(lo);
    end
    if (relu && acc < 0) acc = 0;
    return int'(acc);
  endfunction

  task automatic push_model(input int xv [N]);
    for (int i = 0; i < M; i++) begin
      exp_a.push_back(model(i, xv, 1'b1, 1'b1));
      exp_b.push_back(model(i, xv, 1'b0, 1'b0));
    end
  endtask

  task automatic wait_sready(input string tag);
    int n = 0;
    while (!s_ready_a && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_sready_wait"}, int'(n < 400), 1);
  endtask

  task automatic send_vec(input int xv [N]);
    for (int j = 0; j < N; j++) begin
      s_valid = 1'b1;
      data_in = T'(xv[j]);
      wait_sready("beat");
      @(negedge clk);
    end
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((exp_a.size() + exp_b.size()) != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_drained"}, exp_a.size() + exp_b.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic rand_vec(output int xv [N]);
    for (int j = 0; j < N; j++) xv[j] = int'($urandom_range(0, 2000)) - 1000;
  endtask

  initial begin
    for (int i = 0; i < M*N; i++) w_mem[i] = '0;
    for (int i = 0; i < M; i++) b_mem[i] = '0;

    // reset values, then s_ready rising in the 2nd cycle after release
    repeat (3) @(negedge clk);
    chk("rst_s_ready", s_ready_a, 0);
    chk("rst_m_valid", m_valid_a, 0);
    chk("rst_data_out", dout_a, 0);
    chk("rst_w_addr", wa_a, 0);
    chk("rst_b_addr", ba_a, 0);
    chk("rst_m_valid_b", m_valid_b, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("s_ready_cycle1", s_ready_a, 0);
    @(negedge clk);
    chk("s_ready_cycle2", s_ready_a, 1);

    // identity: y = x, plus first-result latency and row interval
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++) w_mem[i*N+j] = (i == j) ? 20'sd1 : 20'sd0;
    for (int j = 0; j < N; j++) xv1[j] = j + 1;
    for (int i = 0; i < M; i++) begin
      exp_a.push_back(i + 1);
      exp_b.push_back(i + 1);
    end
    send_vec(xv1);
    s_valid = 1'b0;
    k = 1;
    while (!m_valid_a && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("latency_first", k, N + 4);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!m_valid_a && k < 100);
    chk("row_interval", k, N + 3);
    wait_drain("identity");

    // bias only: even rows -100, odd rows +37
    for (int i = 0; i < M*N; i++) w_mem[i] = '0;
    for (int i = 0; i < M; i++) begin
      b_mem[i] = (i % 2 == 0) ? -20'sd100 : 20'sd37;
      exp_a.push_back((i % 2 == 0) ? 0 : 37);
      exp_b.push_back((i % 2 == 0) ? -100 : 37);
    end
    for (int j = 0; j < N; j++) xv1[j] = 3 * j - 11;
    send_vec(xv1);
    s_valid = 1'b0;
    wait_drain("relu_bias");

    // saturation: 8*(2^18-1)^2 clamps to 524287; its low 20 bits equal 8
    for (int i = 0; i < M*N; i++) w_mem[i] = 20'sd262143;
    for (int i = 0; i < M; i++) begin
      b_mem[i] = '0;
      exp_a.push_back(524287);
      exp_b.push_back(8);
    end
    for (int j = 0; j < N; j++) xv1[j] = 262143;
    send_vec(xv1);
    s_valid = 1'b0;
    wait_drain("saturate");

    // back-pressure: 4 random vectors, random m_ready
    for (int i = 0; i < M*N; i++) w_mem[i] = T'(int'($urandom_range(0, 2000)) - 1000);
    for (int i = 0; i < M; i++) b_mem[i] = T'(int'($urandom_range(0, 100000)) - 50000);
    bp_en = 1'b1;
    for (int v = 0; v < 4; v++) begin
      rand_vec(xv1);
      push_model(xv1);
      send_vec(xv1);
    end
    s_valid = 1'b0;
    wait_drain("backpressure");
    bp_en = 1'b0;
    repeat (2) @(negedge clk);

    // ping-pong: 3 vectors with s_valid held high
    base = n_pop_a;
    rand_vec(xv1);
    rand_vec(xv2);
    rand_vec(xv3);
    push_model(xv1);
    push_model(xv2);
    push_model(xv3);
    send_vec(xv1);
    send_vec(xv2);
    chk("pp_sready_low", s_ready_a, 0);
    data_in = T'(xv3[0]);
    wait_sready("pp_release");
    chk("pp_release_with_last_row", m_valid_a, 1);
    send_vec(xv3);
    s_valid = 1'b0;
    chk("pp_rows_before_v2", n_pop_a - base, M);
    wait_drain("pingpong");

    // reset after three outputs, then a fresh vector
    base = n_pop_a;
    rand_vec(xv1);
    push_model(xv1);
    send_vec(xv1);
    s_valid = 1'b0;
    k = 0;
    while (n_pop_a < base + 3 && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("midrow_three_out", int'(n_pop_a >= base + 3), 1);
    @(negedge clk);
    reset = 1'b1;
    exp_a.delete();
    exp_b.delete();
    @(negedge clk);
    chk("midrow_rst_m_valid", m_valid_a, 0);
    chk("midrow_rst_s_ready", s_ready_a, 0);
    chk("midrow_rst_m_valid_b", m_valid_b, 0);
    reset = 1'b0;
    wait_sready("after_reset");
    rand_vec(xv2);
    push_model(xv2);
    send_vec(xv2);
    s_valid = 1'b0;
    wait_drain("after_reset");
    repeat (30) @(negedge clk);
    chk("no_stale_beats", exp_a.size() + exp_b.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
